// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor controller.
package serial_adder_pkg;

  // Controller FSM states. IDLE waits for start, RUN processes one bit per
  // cycle, DONE is the single-cycle completion state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width. The extra bit lets the counter reach WIDTH after the
  // last RUN edge without wrapping, so the terminal compare never aliases.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell: s = a ^ b ^ cin, c = majority(a, b, cin).
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor. One fulladder cell processes one operand bit
// per cycle, LSB first; the result is accumulated into sum from the MSB side.
//
// Handshake: start is a request that is only looked at while busy=0 (IDLE).
// The operands, cin and sub are captured on the same edge that accepts start.
// busy rises on that edge and stays high through RUN and DONE; any start seen
// while busy=1 is dropped. done is a one-cycle pulse during which sum, cout
// and ovf hold the finished result; they stay valid until the edge after the
// next accepted start. A new start may be presented in the IDLE cycle right
// after DONE, giving one operation every WIDTH+2 cycles.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_e           dbg_state_o
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_c;
  logic             c_msb_in;

  // The only arithmetic in the datapath: one bit per cycle.
  fulladder u_fa (
    .a   (opa_q[0]),
    .b   (opb_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  // Carry entering the MSB position; meaningful in the cnt=WIDTH-1 cycle,
  // where it is combined with the carry out of the MSB to detect overflow.
  assign c_msb_in = carry_q;

  // Next value of the result shift register: new bit enters at the MSB so
  // that after WIDTH shifts the first (LSB) bit has reached position 0.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_d = fa_s;
    end else begin : g_sum_wn
      assign sum_d = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // Controller FSM with registered outputs and the serial datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1; cin is ignored in that mode.
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= fa_c;
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            cout_q  <= fa_c;
            ovf_q   <= fa_c ^ c_msb_in;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;
  import serial_adder_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic         start, sub, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  state_e       st;

  // WIDTH=1 instance
  logic         start1, sub1, cin1;
  logic [0:0]   a1, b1;
  logic         busy1, done1, cout1, ovf1;
  logic [0:0]   sum1;
  state_e       st1;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .dbg_state_o(st)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .ovf(ovf1), .dbg_state_o(st1)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];   // {cout, ovf, sum}

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t ref_model(input int w, input longint ua,
                                     input longint ub, input bit c,
                                     input bit s);
    res_t   r;
    longint md, hf, sa, sb, tot, sv;
    md = longint'(1) << w;
    hf = md / 2;
    sa = (ua >= hf) ? ua - md : ua;
    sb = (ub >= hf) ? ub - md : ub;
    if (!s) begin
      tot    = ua + ub + longint'(c);
      r.cout = (tot >= md);
      r.sum  = 32'(tot % md);
      sv     = sa + sb + longint'(c);
    end else begin
      tot    = ua - ub + md;
      r.cout = (ua >= ub);
      r.sum  = 32'(tot % md);
      sv     = sa - sb;
    end
    r.ovf = (sv < -hf) || (sv > hf - 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation and wait for done.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic vs,
                        output logic [W+1:0] got);
    int lat;
    a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
    step();
    start = 1'b0;
    // Captured operands must not follow the inputs any more.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check("busy_after_start", busy, 1);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!done && lat < 64);
    got = {cout, ovf, sum};
    check("latency", lat, W);
    step();
    check("done_single", done, 0);
    check("busy_idle", busy, 0);
  endtask

  // Issue one WIDTH=1 operation and wait for done.
  task automatic run_op1(input logic va, input logic vb, input logic vc,
                         input logic vs, output logic [2:0] got);
    int lat;
    a1 = va; b1 = vb; cin1 = vc; sub1 = vs; start1 = 1'b1;
    step();
    start1 = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!done1 && lat < 16);
    got = {cout1, ovf1, sum1};
    check("w1_latency", lat, 1);
    step();
    check("w1_done_single", done1, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    vec_t         vt[8];
    logic [W+1:0] got, expv;
    logic [2:0]   got1;
    res_t         r;
    int           n_done, first_lat, lat;
    int           pulses[$];

    vt[0] = '{8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vt[2] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[7] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    #2;
    check("reset_outputs", {busy, done, cout, ovf, sum}, 0);
    check("reset_state", st, IDLE);
    step();
    rst_n = 1'b1;

    // Table vectors; the first start lands on the first edge after reset.
    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, got);
      check($sformatf("vec%0d_sum", i), got[W-1:0], vt[i].sum);
      check($sformatf("vec%0d_cout", i), got[W+1], vt[i].cout);
      check($sformatf("vec%0d_ovf", i), got[W], vt[i].ovf);
    end

    // Start pulsed mid-RUN with other operands is ignored.
    a = 8'h21; b = 8'h13; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0; n_done = 0; first_lat = -1;
    repeat (3) begin step(); lat++; end
    a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
    step(); lat++;
    start = 1'b0;
    while (lat < 30) begin
      if (done) begin
        n_done++;
        if (first_lat < 0) begin
          first_lat = lat;
          got = {cout, ovf, sum};
        end
      end
      step(); lat++;
    end
    check("midrun_done_count", n_done, 1);
    check("midrun_latency", first_lat, W);
    check("midrun_result", got, {1'b0, 1'b0, 8'h34});

    // Reset at cnt=4 of an in-flight operation.
    a = 8'h3C; b = 8'h5A; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("pre_reset_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, cout, ovf, sum}, 0);
    check("async_reset_state", st, IDLE);
    n_done = 0;
    repeat (3) begin
      step();
      if (done) n_done++;
    end
    rst_n = 1'b1;
    check("reset_no_done", n_done, 0);
    run_op(8'hC8, 8'h64, 1'b1, 1'b0, got);
    r = ref_model(W, 64'hC8, 64'h64, 1'b1, 1'b0);
    check("post_reset_result", got, {r.cout, r.ovf, r.sum[W-1:0]});

    // Randomized back-to-back operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      r = ref_model(W, longint'(ra), longint'(rb), rc, rs);
      exp_q.push_back({r.cout, r.ovf, r.sum[W-1:0]});
      run_op(ra, rb, rc, rs, got);
      expv = exp_q.pop_front();
      check($sformatf("rand%0d_a%0h_b%0h_c%0b_s%0b", i, ra, rb, rc, rs),
            got, expv);
    end

    // WIDTH=1: all a/b/cin combinations in add mode, plus subtraction.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] bits;
      bits = 3'(i);
      r = ref_model(1, longint'(bits[2]), longint'(bits[1]), bits[0], 1'b0);
      run_op1(bits[2], bits[1], bits[0], 1'b0, got1);
      check($sformatf("w1_add%0d", i), got1, {r.cout, r.ovf, r.sum[0]});
    end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] bits;
      bits = 2'(i);
      r = ref_model(1, longint'(bits[1]), longint'(bits[0]), 1'b0, 1'b1);
      run_op1(bits[1], bits[0], 1'b0, 1'b1, got1);
      check($sformatf("w1_sub%0d", i), got1, {r.cout, r.ovf, r.sum[0]});
    end

    // WIDTH=1 back-to-back: start held high, done every WIDTH+2 cycles.
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (done1) pulses.push_back(c);
    end
    start1 = 1'b0;
    check("w1_b2b_pulses", pulses.size(), 4);
    for (int i = 1; i < pulses.size(); i++)
      check($sformatf("w1_b2b_gap%0d", i), pulses[i] - pulses[i-1], 3);
    check("w1_b2b_result", {cout1, ovf1, sum1}, 3'b100);
    repeat (3) step();

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request a new operation; sampled only in IDLE.
REQ-005 SHALL have port sub, input, 1, 0 = a+b+cin, 1 = a-b (cin ignored); sampled with start.
REQ-006 SHALL have ports a and b, input, WIDTH, operands; sampled with start.
REQ-007 SHALL have port cin, input, 1, carry-in; sampled with start.
REQ-008 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-009 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port sum, output, WIDTH, result register.
REQ-011 SHALL have port cout, output, 1, final carry-out.
REQ-012 SHALL have port ovf, output, 1, two's-complement overflow of the result.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1 at an edge, latch a into opA and b (sub=0) or ~b (sub=1) into opB, load carry with cin (sub=0) or 1 (sub=1), clear bit counter cnt, and enter RUN.
REQ-015 SHALL, in RUN, apply opA[0], opB[0] and carry to one fulladder instance each cycle; at the edge, shift s into sum MSB-side (LSB-first accumulation), load carry with c, right-shift opA and opB, and increment cnt.
REQ-016 SHALL record the full-adder carry-in at the edge where cnt=WIDTH-1 as c_msb_in.
REQ-017 SHALL, at the edge where cnt=WIDTH-1, enter DONE with sum holding the complete result, cout=c and ovf=c XOR c_msb_in.
REQ-018 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE at the next edge.
REQ-019 SHALL assert done in the cycle following the WIDTH-th edge after the start-sampling edge, giving latency WIDTH cycles from start to done and a throughput of one operation per WIDTH+2 cycles.
REQ-020 SHALL ignore start while busy=1; operands and mode already captured remain unaffected.
REQ-021 SHALL keep sum, cout and ovf stable from DONE until the edge following the next accepted start.
REQ-022 SHALL use WIDTH-derived counter width clog2(WIDTH)+1 with no wrap before terminal count.
REQ-023 SHALL, when WIDTH=1, spend exactly one cycle in RUN.
REQ-024 SHALL accept start in the IDLE cycle immediately after DONE (back-to-back operation).
REQ-025 SHALL make sum/cout in subtract mode equal to a-b modulo 2^WIDTH and NOT borrow respectively.

Reset
REQ-026 SHALL, on rst_n=0, immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, cnt=0 and carry=0, independent of clk.
REQ-027 SHALL abort any in-flight operation on reset without producing a done pulse.
REQ-028 SHALL accept start at the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, RUN, DONE) and the counter-width function in shared package serial_adder_pkg.
REQ-030 SHALL instantiate the existing one-bit cell fulladder (ports a, b, cin, s, c) as its only sub-module; no other arithmetic is permitted in the datapath.
REQ-031 SHALL register all outputs; no output is combinationally derived from inputs.

Verification
REQ-032 SHALL verify that, with WIDTH=8, a=8'h3C, b=8'h5A, cin=0, sub=0, the response is sum=8'h96, cout=0, ovf=1, with done exactly 8 cycles after start.
REQ-033 SHALL verify that, with a=8'hFF, b=8'h01, cin=1, sub=0, the response is sum=8'h01, cout=1, ovf=0.
REQ-034 SHALL verify that, with a=8'h10, b=8'h20, sub=1, the response is sum=8'hF0, cout=0, ovf=0; and that a=8'h80, b=8'h01, sub=1 gives sum=8'h7F, cout=1, ovf=1.
REQ-035 SHALL verify that start pulsed mid-RUN with different operands leaves the first result unchanged and produces a single done pulse.
REQ-036 SHALL verify that rst_n pulsed low at cnt=4 forces all outputs to 0 asynchronously, produces no done, and that a new start afterwards completes normally.
REQ-037 SHALL verify, for WIDTH=1, all 8 combinations of a, b and cin against a+b+cin, and back-to-back starts with done spaced WIDTH+2 cycles apart.
